// File: rtl/noc_wormhole_output_allocator.sv
// Wormhole output-port allocator. A head flit wins round-robin arbitration and the
// output stays locked to that input until its tail flit transfers under credit flow control.
module noc_wormhole_output_allocator #(
    parameter int NUM_PORTS    = 5,
    parameter int CREDIT_DEPTH = 4,
    parameter int IDX_W        = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [NUM_PORTS-1:0] req_head,
    input  logic [NUM_PORTS-1:0] req_tail,
    input  logic                 credit_in,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] xfer,
    output logic                 out_valid,
    output logic [IDX_W-1:0]     owner_idx,
    output logic [3:0]           credits,
    output logic                 credit_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);
    localparam logic [3:0]       CRED_MAX = 4'(CREDIT_DEPTH);

    state_t               state_r;
    state_t               state_s;
    logic [IDX_W-1:0]     owner_r;
    logic [IDX_W-1:0]     owner_s;
    logic [IDX_W-1:0]     prio_ptr_r;
    logic [IDX_W-1:0]     prio_ptr_s;
    logic [3:0]           credits_r;
    logic [3:0]           credits_s;
    logic                 credit_err_r;
    logic                 credit_err_s;
    logic [NUM_PORTS-1:0] grant_s;
    logic [NUM_PORTS-1:0] xfer_s;
    logic [IDX_W-1:0]     owner_idx_s;
    logic [NUM_PORTS-1:0] eligible_s;
    logic [IDX_W:0]       pick_s;

    // Round-robin search starting at ptr; MSB of the result flags that a winner exists.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_PORTS-1:0] elig,
                                               input logic [IDX_W-1:0]     ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end else begin
                idx = idx;
            end
            if (elig[idx] && !res[IDX_W]) begin
                res = {1'b1, IDX_W'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign eligible_s = req_valid & req_head;
    assign pick_s     = rr_pick(eligible_s, prio_ptr_r);

    // Next-state, owner/pointer update and the combinational grant/xfer strobes.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        prio_ptr_s  = prio_ptr_r;
        grant_s     = '0;
        xfer_s      = '0;
        owner_idx_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[IDX_W]) begin
                    owner_s = pick_s[IDX_W-1:0];
                    state_s = ST_LOCKED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                grant_s[owner_r] = 1'b1;
                owner_idx_s      = owner_r;
                // A stalled owner keeps the lock indefinitely; only a tail transfer releases it.
                if (req_valid[owner_r] && (credits_r != 4'd0)) begin
                    xfer_s[owner_r] = 1'b1;
                    if (req_tail[owner_r]) begin
                        state_s    = ST_IDLE;
                        prio_ptr_s = (owner_r == LAST_IDX) ? '0 : owner_r + IDX_W'(1);
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Credit counter: a transfer consumes a slot, credit_in returns one; both at once cancel.
    always_comb begin
        credits_s    = credits_r;
        credit_err_s = credit_err_r;
        case ({credit_in, |xfer_s})
            2'b10: begin
                if (credits_r == CRED_MAX) begin
                    credit_err_s = 1'b1;
                end else begin
                    credits_s = credits_r + 4'd1;
                end
            end
            2'b01:   credits_s = credits_r - 4'd1;
            default: credits_s = credits_r;
        endcase
    end

    // State, owner, priority pointer and credit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            owner_r      <= '0;
            prio_ptr_r   <= '0;
            credits_r    <= CRED_MAX;
            credit_err_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            prio_ptr_r   <= prio_ptr_s;
            credits_r    <= credits_s;
            credit_err_r <= credit_err_s;
        end
    end

    assign grant      = grant_s;
    assign xfer       = xfer_s;
    assign out_valid  = |xfer_s;
    assign owner_idx  = owner_idx_s;
    assign credits    = credits_r;
    assign credit_err = credit_err_r;

endmodule

// File: tb/tb_noc_wormhole_output_allocator.sv
// Directed bench for noc_wormhole_output_allocator (5 ports, 4 credits) with hand-computed
// expectations checked by immediate assertions.
module tb_noc_wormhole_output_allocator;

    logic       clk;
    logic       rst_n;
    logic [4:0] req_valid;
    logic [4:0] req_head;
    logic [4:0] req_tail;
    logic       credit_in;
    logic [4:0] grant;
    logic [4:0] xfer;
    logic       out_valid;
    logic [2:0] owner_idx;
    logic [3:0] credits;
    logic       credit_err;

    int checks   = 0;
    int failures = 0;

    // Per-input packet source: flit position, packet length, stall mask, raw body-flit override.
    int         pos [5];
    int         len [5];
    logic [4:0] stall;
    logic [4:0] extra_body;

    noc_wormhole_output_allocator #(
        .NUM_PORTS   (5),
        .CREDIT_DEPTH(4),
        .IDX_W       (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_head  (req_head),
        .req_tail  (req_tail),
        .credit_in (credit_in),
        .grant     (grant),
        .xfer      (xfer),
        .out_valid (out_valid),
        .owner_idx (owner_idx),
        .credits   (credits),
        .credit_err(credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present();
        for (int i = 0; i < 5; i++) begin
            logic v;
            v = (pos[i] < len[i]) && !stall[i];
            req_valid[i] = v | extra_body[i];
            req_head[i]  = v && (pos[i] == 0);
            req_tail[i]  = v && (pos[i] == len[i] - 1);
        end
    endtask

    // One cycle: drive, check outputs mid-cycle, clock, then advance sources that transferred.
    task automatic step(input string tag, input logic [4:0] eg, input logic [4:0] ex,
                        input logic [2:0] eo, input logic [3:0] ec);
        present();
        #1;
        chk({tag, ".grant"},     32'(grant),     32'(eg));
        chk({tag, ".xfer"},      32'(xfer),      32'(ex));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(|ex));
        chk({tag, ".owner_idx"}, 32'(owner_idx), 32'(eo));
        chk({tag, ".credits"},   32'(credits),   32'(ec));
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (ex[i]) pos[i] = pos[i] + 1;
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < 5; i++) begin
            pos[i] = 0;
            len[i] = 0;
        end
        stall      = 5'b00000;
        extra_body = 5'b00000;
        credit_in  = 1'b0;
        present();
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        clear_sources();
        @(posedge clk);
        #1;
        chk({tag, ".rst_grant"},   32'(grant),      32'(5'b00000));
        chk({tag, ".rst_xfer"},    32'(xfer),       32'(5'b00000));
        chk({tag, ".rst_ovalid"},  32'(out_valid),  32'(1'b0));
        chk({tag, ".rst_owner"},   32'(owner_idx),  32'(3'd0));
        chk({tag, ".rst_credits"}, 32'(credits),    32'(4'd4));
        chk({tag, ".rst_err"},     32'(credit_err), 32'(1'b0));
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_sources();
        #2;
        do_reset("init");

        // Single-flit packet on input 2; pointer then moves to 3.
        len[2] = 1;
        step("t1.idle",   5'b00000, 5'b00000, 3'd0, 4'd4);
        step("t1.lock",   5'b00100, 5'b00100, 3'd2, 4'd4);
        step("t1.after",  5'b00000, 5'b00000, 3'd0, 4'd3);

        // Pointer at 3: input 4 beats input 1; then pointer 0 lets input 1 win.
        len[4] = 1;
        len[1] = 1;
        step("rr.idle1",  5'b00000, 5'b00000, 3'd0, 4'd3);
        step("rr.own4",   5'b10000, 5'b10000, 3'd4, 4'd3);
        step("rr.idle2",  5'b00000, 5'b00000, 3'd0, 4'd2);
        step("rr.own1",   5'b00010, 5'b00010, 3'd1, 4'd2);
        step("rr.idle3",  5'b00000, 5'b00000, 3'd0, 4'd1);

        // Async reset mid-packet while LOCKED with credits=1 (pointer is 2 here).
        len[3] = 4;
        step("t6.idle",   5'b00000, 5'b00000, 3'd0, 4'd1);
        present();
        #1;
        chk("t6.pre_grant",   32'(grant),   32'(5'b01000));
        chk("t6.pre_credits", 32'(credits), 32'(4'd1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.rst_grant",   32'(grant),     32'(5'b00000));
        chk("t6.rst_xfer",    32'(xfer),      32'(5'b00000));
        chk("t6.rst_ovalid",  32'(out_valid), 32'(1'b0));
        chk("t6.rst_owner",   32'(owner_idx), 32'(3'd0));
        chk("t6.rst_credits", 32'(credits),   32'(4'd4));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        pos[1] = 0;
        len[1] = 1;
        // Heads on 1 and 3: a cleared pointer picks input 1.
        step("t6.idle",   5'b00000, 5'b00000, 3'd0, 4'd4);
        step("t6.ptr0",   5'b00010, 5'b00010, 3'd1, 4'd4);

        // Two 3-flit packets on inputs 0 and 3; credit_in together with xfer holds the count.
        do_reset("t2");
        len[0] = 3;
        len[3] = 3;
        step("t2.idle",   5'b00000, 5'b00000, 3'd0, 4'd4);
        step("t2.a0",     5'b00001, 5'b00001, 3'd0, 4'd4);
        step("t2.a1",     5'b00001, 5'b00001, 3'd0, 4'd3);
        credit_in = 1'b1;
        step("t2.a2_ci",  5'b00001, 5'b00001, 3'd0, 4'd2);
        credit_in = 1'b0;
        step("t2.bubble", 5'b00000, 5'b00000, 3'd0, 4'd2);
        step("t2.b0",     5'b01000, 5'b01000, 3'd3, 4'd2);
        credit_in = 1'b1;
        step("t2.b1_ci",  5'b01000, 5'b01000, 3'd3, 4'd1);
        credit_in = 1'b0;
        step("t2.b2",     5'b01000, 5'b01000, 3'd3, 4'd1);
        step("t2.end",    5'b00000, 5'b00000, 3'd0, 4'd0);

        // 6-flit packet with only 4 credits: stall at zero, one flit per returned credit.
        do_reset("t3");
        len[2] = 6;
        step("t3.idle",   5'b00000, 5'b00000, 3'd0, 4'd4);
        step("t3.f0",     5'b00100, 5'b00100, 3'd2, 4'd4);
        step("t3.f1",     5'b00100, 5'b00100, 3'd2, 4'd3);
        step("t3.f2",     5'b00100, 5'b00100, 3'd2, 4'd2);
        step("t3.f3",     5'b00100, 5'b00100, 3'd2, 4'd1);
        step("t3.stall0", 5'b00100, 5'b00000, 3'd2, 4'd0);
        step("t3.stall1", 5'b00100, 5'b00000, 3'd2, 4'd0);
        credit_in = 1'b1;
        step("t3.ci1",    5'b00100, 5'b00000, 3'd2, 4'd0);
        credit_in = 1'b0;
        step("t3.f4",     5'b00100, 5'b00100, 3'd2, 4'd1);
        step("t3.stall2", 5'b00100, 5'b00000, 3'd2, 4'd0);
        credit_in = 1'b1;
        step("t3.ci2",    5'b00100, 5'b00000, 3'd2, 4'd0);
        credit_in = 1'b0;
        step("t3.f5",     5'b00100, 5'b00100, 3'd2, 4'd1);
        step("t3.idle2",  5'b00000, 5'b00000, 3'd0, 4'd0);

        // Credit overflow in IDLE: count saturates, error is sticky until reset.
        do_reset("t4");
        credit_in = 1'b1;
        step("t4.ovf",    5'b00000, 5'b00000, 3'd0, 4'd4);
        credit_in = 1'b0;
        chk("t4.err_set",   32'(credit_err), 32'(1'b1));
        step("t4.hold",   5'b00000, 5'b00000, 3'd0, 4'd4);
        chk("t4.err_stick", 32'(credit_err), 32'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("t4.err_clr",   32'(credit_err), 32'(1'b0));
        do_reset("t5");

        // Body flit alone never locks.
        extra_body = 5'b00010;
        step("t5.body0",  5'b00000, 5'b00000, 3'd0, 4'd4);
        step("t5.body1",  5'b00000, 5'b00000, 3'd0, 4'd4);
        extra_body = 5'b00000;

        // Owner 1 stalls for 3 cycles; input 4 waits and is served after the tail.
        len[1] = 4;
        len[4] = 1;
        step("t5.idle",   5'b00000, 5'b00000, 3'd0, 4'd4);
        step("t5.h",      5'b00010, 5'b00010, 3'd1, 4'd4);
        stall = 5'b00010;
        step("t5.s0",     5'b00010, 5'b00000, 3'd1, 4'd3);
        step("t5.s1",     5'b00010, 5'b00000, 3'd1, 4'd3);
        step("t5.s2",     5'b00010, 5'b00000, 3'd1, 4'd3);
        stall = 5'b00000;
        step("t5.b1",     5'b00010, 5'b00010, 3'd1, 4'd3);
        step("t5.b2",     5'b00010, 5'b00010, 3'd1, 4'd2);
        step("t5.t",      5'b00010, 5'b00010, 3'd1, 4'd1);
        step("t5.bub",    5'b00000, 5'b00000, 3'd0, 4'd0);
        step("t5.own4",   5'b10000, 5'b00000, 3'd4, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
